// File: rtl/parse_pkg.sv
// Shared action-field layout, size codes and scheduler state encodings for the
// parse action scheduler and its per-lane checker.
package parse_pkg;

  localparam int ACT_VALID_BIT = 0;
  localparam int ACT_SIZE_LSB  = 4;
  localparam int ACT_SIZE_W    = 2;
  localparam int ACT_OFF_LSB   = 6;
  localparam int ACT_OFF_W     = 7;

  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_2B   = 2'b01,
    SZ_4B   = 2'b10,
    SZ_6B   = 2'b11
  } size_code_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DRAIN = 2'b10
  } sched_state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] code);
    case (code)
      SZ_2B:   return 4'd2;
      SZ_4B:   return 4'd4;
      SZ_6B:   return 4'd6;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/parse_act_check.sv
// Combinational validity / header-bounds check for one parse action.
// Bounds suppression is active only when PARSE_BOUNDS_CHECK_EN is defined.
module parse_act_check
  import parse_pkg::*;
#(
  parameter int PARSE_ACT_LEN = 16,
  parameter int HDR_BYTES     = 128
) (
  input  logic [PARSE_ACT_LEN-1:0] act_i,
  output logic                     issue_o,
  output logic                     oob_o
);

  logic [ACT_SIZE_W-1:0] size_code;
  logic [ACT_OFF_W-1:0]  offset;
  logic [3:0]            nbytes;
  logic [7:0]            end_byte;
  logic                  live;
  logic                  exceeds;
  logic                  unused_act;

  assign size_code = act_i[ACT_SIZE_LSB +: ACT_SIZE_W];
  assign offset    = act_i[ACT_OFF_LSB +: ACT_OFF_W];
  assign nbytes    = size_bytes(size_code);
  assign live      = act_i[ACT_VALID_BIT] && (size_code != SZ_NONE);
  // One past the last byte touched; 127+6 needs 8 bits.
  assign end_byte  = 8'(offset) + 8'(nbytes);
  assign exceeds   = int'(end_byte) > HDR_BYTES;

`ifdef PARSE_BOUNDS_CHECK_EN
  assign issue_o = live && !exceeds;
  assign oob_o   = live && exceeds;
`else
  logic unused_bounds;
  assign issue_o       = live;
  assign oob_o         = 1'b0;
  assign unused_bounds = exceeds;
`endif

  assign unused_act = ^act_i;

endmodule

// File: rtl/parse_act_sched.sv
// Issues a registered action list NUM_LANES entries per cycle to the sub-parser
// lanes, then pulses sched_done. Optional bounds check: PARSE_BOUNDS_CHECK_EN.
module parse_act_sched
  import parse_pkg::*;
#(
  parameter int NUM_ACTS      = 10,
  parameter int NUM_LANES     = 2,
  parameter int PARSE_ACT_LEN = 16,
  parameter int HDR_BYTES     = 128
) (
  input  logic                               clk,
  input  logic                               aresetn,
  input  logic                               act_list_valid,
  input  logic [NUM_ACTS*PARSE_ACT_LEN-1:0]  act_list,
  output logic                               act_list_ready,
  output logic [NUM_LANES-1:0]               lane_act_valid,
  output logic [NUM_LANES*PARSE_ACT_LEN-1:0] lane_act,
  output logic                               sched_done,
  output logic [3:0]                         issued_cnt,
  output logic                               err_oob
);

  localparam int GROUPS = (NUM_ACTS + NUM_LANES - 1) / NUM_LANES;
  localparam int SLOTS  = GROUPS * NUM_LANES;
  localparam int PTR_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int IDX_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(GROUPS - 1);

  sched_state_e                       state_q, state_d;
  logic [PTR_W-1:0]                   ptr_q, ptr_d;
  logic [NUM_ACTS*PARSE_ACT_LEN-1:0]  list_q, list_d;
  logic [NUM_LANES*PARSE_ACT_LEN-1:0] hold_q, hold_d;
  logic [3:0]                         cnt_q, cnt_d;
  logic                               err_q, err_d;

  logic [PARSE_ACT_LEN-1:0]           slot [SLOTS];
  logic [NUM_LANES*PARSE_ACT_LEN-1:0] cur_act;
  logic [NUM_LANES-1:0]               cur_issue;
  logic [NUM_LANES-1:0]               cur_oob;
  logic [3:0]                         pop;

  // Pad the last partial group with all-zero slots so they never issue.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : slot_g
    if (gi < NUM_ACTS) begin : g_real
      assign slot[gi] = list_q[gi*PARSE_ACT_LEN +: PARSE_ACT_LEN];
    end else begin : g_pad
      assign slot[gi] = '0;
    end
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : lane_g
    logic [IDX_W-1:0] idx;
    assign idx = IDX_W'(int'(ptr_q) * NUM_LANES + gi);
    assign cur_act[gi*PARSE_ACT_LEN +: PARSE_ACT_LEN] = slot[idx];

    parse_act_check #(
      .PARSE_ACT_LEN (PARSE_ACT_LEN),
      .HDR_BYTES     (HDR_BYTES)
    ) u_check (
      .act_i   (slot[idx]),
      .issue_o (cur_issue[gi]),
      .oob_o   (cur_oob[gi])
    );
  end

  always_comb begin
    pop = '0;
    for (int k = 0; k < NUM_LANES; k++) pop = pop + 4'(cur_issue[k]);
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    list_d         = list_q;
    hold_d         = hold_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    act_list_ready = 1'b0;
    lane_act_valid = '0;
    lane_act       = hold_q;
    sched_done     = 1'b0;
    case (state_q)
      IDLE: begin
        act_list_ready = 1'b1;
        if (act_list_valid) begin
          list_d  = act_list;
          ptr_d   = '0;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        lane_act_valid = cur_issue;
        lane_act       = cur_act;
        hold_d         = cur_act;
        cnt_d          = cnt_q + pop;
        err_d          = err_q | (|cur_oob);
        if (ptr_q == LAST_PTR) begin
          ptr_d   = '0;
          state_d = DRAIN;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      DRAIN: begin
        // Lanes have one cycle of latency, so results are complete here.
        sched_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      list_q  <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      list_q  <= list_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign issued_cnt = cnt_q;
  assign err_oob    = err_q;

endmodule

// File: tb/tb_parse_act_sched.sv
// Directed bench for parse_act_sched: default 10x2 instance plus a 5-action
// instance for the partial last group. Bounds expectations follow PARSE_BOUNDS_CHECK_EN.
`timescale 1ns/1ps
module tb_parse_act_sched;

  localparam int LEN = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              aresetn;
  logic              act_list_valid;
  logic [10*LEN-1:0] act_list;
  logic              act_list_ready;
  logic [1:0]        lane_act_valid;
  logic [2*LEN-1:0]  lane_act;
  logic              sched_done;
  logic [3:0]        issued_cnt;
  logic              err_oob;

  logic              s_valid;
  logic [5*LEN-1:0]  s_list;
  logic              s_ready;
  logic [1:0]        s_lav;
  logic [2*LEN-1:0]  s_la;
  logic              s_done;
  logic [3:0]        s_cnt;
  logic              s_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] e  [10];
  logic [15:0] se [5];

  parse_act_sched dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .act_list_valid (act_list_valid),
    .act_list       (act_list),
    .act_list_ready (act_list_ready),
    .lane_act_valid (lane_act_valid),
    .lane_act       (lane_act),
    .sched_done     (sched_done),
    .issued_cnt     (issued_cnt),
    .err_oob        (err_oob)
  );

  parse_act_sched #(.NUM_ACTS(5), .NUM_LANES(2)) dut_small (
    .clk            (clk),
    .aresetn        (aresetn),
    .act_list_valid (s_valid),
    .act_list       (s_list),
    .act_list_ready (s_ready),
    .lane_act_valid (s_lav),
    .lane_act       (s_la),
    .sched_done     (s_done),
    .issued_cnt     (s_cnt),
    .err_oob        (s_err)
  );

  function automatic logic [15:0] mk(input logic v, input logic [2:0] seq,
                                     input logic [1:0] sz, input logic [6:0] off);
    return {3'b000, off, sz, seq, v};
  endfunction

  task automatic load_main();
    for (int i = 0; i < 10; i++) act_list[i*LEN +: LEN] = e[i];
  endtask

  task automatic fill_2b(input int base);
    for (int i = 0; i < 10; i++) e[i] = mk(1'b1, 3'(i), 2'b01, 7'(base + i));
  endtask

  task automatic test_reset();
    aresetn = 1'b0; act_list_valid = 1'b0; act_list = '0; s_valid = 1'b0; s_list = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (act_list_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", act_list_ready); end
    n_cmp++; if (lane_act_valid !== 2'b00) begin n_bad++; $display("FAIL reset_lav: got %b want 00", lane_act_valid); end
    n_cmp++; if (lane_act !== 32'h0) begin n_bad++; $display("FAIL reset_lane_act: got %h want 0", lane_act); end
    n_cmp++; if (sched_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", sched_done); end
    n_cmp++; if (issued_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", issued_cnt); end
    n_cmp++; if (err_oob !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_oob); end
    n_cmp++; if (s_lav !== 2'b00 || s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_small: got lav=%b ready=%b want 00/1", s_lav, s_ready); end
    aresetn = 1'b1;
    @(negedge clk);
    n_cmp++; if (act_list_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", act_list_ready); end
    $display("reset: done");
  endtask

  task automatic test_all_valid();
    logic [31:0] exp_act;
    fill_2b(0); load_main();
    act_list_valid = 1'b1;
    n_cmp++; if (act_list_ready !== 1'b1) begin n_bad++; $display("FAIL all_ready_at_xfer: got %b want 1", act_list_ready); end
    @(negedge clk); act_list_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      exp_act = {e[2*c-1], e[2*c-2]};
      n_cmp++; if (lane_act_valid !== 2'b11) begin n_bad++; $display("FAIL all_lav c%0d: got %b want 11", c, lane_act_valid); end
      n_cmp++; if (lane_act !== exp_act) begin n_bad++; $display("FAIL all_lane_act c%0d: got %h want %h", c, lane_act, exp_act); end
      n_cmp++; if (issued_cnt !== 4'(2*(c-1))) begin n_bad++; $display("FAIL all_cnt c%0d: got %0d want %0d", c, issued_cnt, 2*(c-1)); end
      n_cmp++; if (sched_done !== 1'b0 || act_list_ready !== 1'b0) begin n_bad++; $display("FAIL all_issue_ctl c%0d: got done=%b ready=%b want 0/0", c, sched_done, act_list_ready); end
      @(negedge clk);
    end
    exp_act = {e[9], e[8]};
    n_cmp++; if (sched_done !== 1'b1) begin n_bad++; $display("FAIL all_done_c6: got %b want 1", sched_done); end
    n_cmp++; if (lane_act_valid !== 2'b00) begin n_bad++; $display("FAIL all_drain_lav: got %b want 00", lane_act_valid); end
    n_cmp++; if (lane_act !== exp_act) begin n_bad++; $display("FAIL all_drain_hold: got %h want %h", lane_act, exp_act); end
    n_cmp++; if (issued_cnt !== 4'd10) begin n_bad++; $display("FAIL all_cnt_done: got %0d want 10", issued_cnt); end
    @(negedge clk);
    n_cmp++; if (sched_done !== 1'b0 || act_list_ready !== 1'b1) begin n_bad++; $display("FAIL all_idle_c7: got done=%b ready=%b want 0/1", sched_done, act_list_ready); end
    n_cmp++; if (issued_cnt !== 4'd10) begin n_bad++; $display("FAIL all_cnt_hold: got %0d want 10", issued_cnt); end
    $display("list all_valid: issued=%0d", issued_cnt);
  endtask

  task automatic test_some_invalid();
    logic [1:0] pat [5];
    pat = '{2'b01, 2'b11, 2'b10, 2'b01, 2'b11};
    fill_2b(0);
    e[1][0] = 1'b0; e[4][0] = 1'b0; e[7][0] = 1'b0;
    load_main();
    act_list_valid = 1'b1;
    @(negedge clk); act_list_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      n_cmp++; if (lane_act_valid !== pat[c-1]) begin n_bad++; $display("FAIL inv_lav c%0d: got %b want %b", c, lane_act_valid, pat[c-1]); end
      @(negedge clk);
    end
    n_cmp++; if (sched_done !== 1'b1 || issued_cnt !== 4'd7) begin n_bad++; $display("FAIL inv_done: got done=%b cnt=%0d want 1/7", sched_done, issued_cnt); end
    @(negedge clk);
    $display("list some_invalid: issued=%0d", issued_cnt);
  endtask

  task automatic test_back_to_back();
    logic [15:0] a [10];
    logic [31:0] exp_act;
    int zeros;
    fill_2b(0); load_main();
    a = e;
    act_list_valid = 1'b1;
    n_cmp++; if (act_list_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_first: got %b want 1", act_list_ready); end
    @(negedge clk);
    for (int i = 0; i < 10; i++) e[i] = mk(1'b1, 3'(i), 2'b10, 7'(20 + i));
    load_main();
    exp_act = {a[1], a[0]};
    n_cmp++; if (lane_act !== exp_act) begin n_bad++; $display("FAIL b2b_list_a_c1: got %h want %h", lane_act, exp_act); end
    zeros = 0;
    for (int k = 0; k < 12; k++) begin
      if (act_list_ready === 1'b1) break;
      if (zeros == 3) begin
        exp_act = {a[7], a[6]};
        n_cmp++; if (lane_act !== exp_act) begin n_bad++; $display("FAIL b2b_list_a_c4: got %h want %h", lane_act, exp_act); end
      end
      zeros++;
      @(negedge clk);
    end
    n_cmp++; if (zeros != 6) begin n_bad++; $display("FAIL b2b_not_ready_cycles: got %0d want 6", zeros); end
    @(negedge clk); act_list_valid = 1'b0;
    exp_act = {e[1], e[0]};
    n_cmp++; if (lane_act_valid !== 2'b11 || lane_act !== exp_act) begin n_bad++; $display("FAIL b2b_list_b_c1: got lav=%b act=%h want 11/%h", lane_act_valid, lane_act, exp_act); end
    n_cmp++; if (issued_cnt !== 4'd0) begin n_bad++; $display("FAIL b2b_cnt_cleared: got %0d want 0", issued_cnt); end
    repeat (5) @(negedge clk);
    n_cmp++; if (sched_done !== 1'b1 || issued_cnt !== 4'd10) begin n_bad++; $display("FAIL b2b_done_b: got done=%b cnt=%0d want 1/10", sched_done, issued_cnt); end
    @(negedge clk);
    $display("lists back_to_back: gap=%0d issued=%0d", zeros, issued_cnt);
  endtask

  task automatic test_bounds();
    logic [1:0] exp_lav;
    logic [3:0] exp_cnt;
    logic       exp_err;
`ifdef PARSE_BOUNDS_CHECK_EN
    exp_lav = 2'b10; exp_cnt = 4'd9;  exp_err = 1'b1;
`else
    exp_lav = 2'b11; exp_cnt = 4'd10; exp_err = 1'b0;
`endif
    fill_2b(0);
    e[0] = mk(1'b1, 3'd0, 2'b11, 7'd125);
    e[1] = mk(1'b1, 3'd1, 2'b11, 7'd122);
    load_main();
    act_list_valid = 1'b1;
    @(negedge clk); act_list_valid = 1'b0;
    n_cmp++; if (lane_act_valid !== exp_lav) begin n_bad++; $display("FAIL oob_lav_c1: got %b want %b", lane_act_valid, exp_lav); end
    n_cmp++; if (lane_act !== {e[1], e[0]}) begin n_bad++; $display("FAIL oob_lane_act_c1: got %h want %h", lane_act, {e[1], e[0]}); end
    n_cmp++; if (err_oob !== 1'b0) begin n_bad++; $display("FAIL oob_err_c1: got %b want 0", err_oob); end
    @(negedge clk);
    n_cmp++; if (err_oob !== exp_err) begin n_bad++; $display("FAIL oob_err_c2: got %b want %b", err_oob, exp_err); end
    repeat (4) @(negedge clk);
    n_cmp++; if (sched_done !== 1'b1 || issued_cnt !== exp_cnt) begin n_bad++; $display("FAIL oob_done: got done=%b cnt=%0d want 1/%0d", sched_done, issued_cnt, exp_cnt); end
    @(negedge clk);
    fill_2b(0); load_main();
    act_list_valid = 1'b1;
    @(negedge clk); act_list_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (sched_done !== 1'b1 || issued_cnt !== 4'd10) begin n_bad++; $display("FAIL oob_next_done: got done=%b cnt=%0d want 1/10", sched_done, issued_cnt); end
    n_cmp++; if (err_oob !== exp_err) begin n_bad++; $display("FAIL oob_err_sticky: got %b want %b", err_oob, exp_err); end
    @(negedge clk);
    $display("list bounds: err_oob=%b issued=%0d", err_oob, issued_cnt);
  endtask

  task automatic test_reset_mid();
    int seen;
    fill_2b(0); load_main();
    act_list_valid = 1'b1;
    @(negedge clk); act_list_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (lane_act_valid !== 2'b11 || issued_cnt !== 4'd4) begin n_bad++; $display("FAIL rst_mid_c3: got lav=%b cnt=%0d want 11/4", lane_act_valid, issued_cnt); end
    aresetn = 1'b0;
    @(negedge clk);
    n_cmp++; if (lane_act_valid !== 2'b00 || lane_act !== 32'h0) begin n_bad++; $display("FAIL rst_mid_lane: got lav=%b act=%h want 00/0", lane_act_valid, lane_act); end
    n_cmp++; if (sched_done !== 1'b0 || issued_cnt !== 4'd0 || err_oob !== 1'b0) begin n_bad++; $display("FAIL rst_mid_status: got done=%b cnt=%0d err=%b want 0/0/0", sched_done, issued_cnt, err_oob); end
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    n_cmp++; if (act_list_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 1", act_list_ready); end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (sched_done === 1'b1) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", seen); end
    $display("list reset_mid: abandoned");
  endtask

  task automatic test_small();
    logic [1:0]  pat [3];
    logic [31:0] exp_act [3];
    pat = '{2'b11, 2'b11, 2'b01};
    for (int i = 0; i < 5; i++) begin
      se[i] = mk(1'b1, 3'(i), 2'b01, 7'(40 + i));
      s_list[i*LEN +: LEN] = se[i];
    end
    exp_act[0] = {se[1], se[0]};
    exp_act[1] = {se[3], se[2]};
    exp_act[2] = {16'h0000, se[4]};
    s_valid = 1'b1;
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL small_ready: got %b want 1", s_ready); end
    @(negedge clk); s_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      n_cmp++; if (s_lav !== pat[c-1]) begin n_bad++; $display("FAIL small_lav c%0d: got %b want %b", c, s_lav, pat[c-1]); end
      n_cmp++; if (s_la !== exp_act[c-1]) begin n_bad++; $display("FAIL small_act c%0d: got %h want %h", c, s_la, exp_act[c-1]); end
      @(negedge clk);
    end
    n_cmp++; if (s_done !== 1'b1 || s_cnt !== 4'd5 || s_lav !== 2'b00) begin n_bad++; $display("FAIL small_done: got done=%b cnt=%0d lav=%b want 1/5/00", s_done, s_cnt, s_lav); end
    @(negedge clk);
    n_cmp++; if (s_done !== 1'b0 || s_ready !== 1'b1) begin n_bad++; $display("FAIL small_idle: got done=%b ready=%b want 0/1", s_done, s_ready); end
    $display("list small: issued=%0d", s_cnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_all_valid();
    test_some_invalid();
    test_back_to_back();
    test_bounds();
    test_reset_mid();
    test_small();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/parse_act_sched.md
PARSE_ACT_SCHED -- requirements
Module: parse_act_sched

Interface
REQ-001 SHALL have parameter NUM_ACTS, default 10, the number of parse actions per action list.
REQ-002 SHALL have parameter NUM_LANES, default 2, the number of sub-parser lanes driven in parallel.
REQ-003 SHALL have parameter PARSE_ACT_LEN, default 16, the width of one action: [0] valid, [3:1] seq, [5:4] size code, [12:6] byte offset.
REQ-004 SHALL have parameter HDR_BYTES, default 128, the number of header bytes visible to the lanes.
REQ-005 SHALL have port clk, input, 1 bit, clock.
REQ-006 SHALL have port aresetn, input, 1 bit, reset; synchronous, active-low.
REQ-007 SHALL have port act_list_valid, input, 1 bit, action list offered.
REQ-008 SHALL have port act_list, input, NUM_ACTS*PARSE_ACT_LEN bits; entry i occupies [i*PARSE_ACT_LEN +: PARSE_ACT_LEN].
REQ-009 SHALL have port act_list_ready, output, 1 bit, scheduler can accept a list.
REQ-010 SHALL have port lane_act_valid, output, NUM_LANES bits, per-lane action strobe.
REQ-011 SHALL have port lane_act, output, NUM_LANES*PARSE_ACT_LEN bits, per-lane action.
REQ-012 SHALL have port sched_done, output, 1 bit, one-cycle pulse when all lane results for the list are available.
REQ-013 SHALL have port issued_cnt, output, 4 bits, count of actions issued for the current list.
REQ-014 SHALL have port err_oob, output, 1 bit, sticky out-of-bounds flag (see Configuration).

Function
REQ-015 SHALL implement an FSM with states IDLE, ISSUE and DRAIN.
REQ-016 SHALL drive act_list_ready=1 only in IDLE; a transfer occurs on act_list_valid && act_list_ready.
REQ-017 SHALL, on transfer, register act_list internally, clear the group pointer and issued_cnt, and enter ISSUE.
REQ-018 SHALL, in ISSUE, present entries ptr*NUM_LANES+k on lane k each cycle, then increment ptr.
REQ-019 SHALL set lane_act_valid[k]=1 only when entry bit[0]=1 and size code!=00; entries past NUM_ACTS (last partial group) SHALL drive valid 0 and act 0.
REQ-020 SHALL, in ISSUE, add the number of asserted lane_act_valid bits to issued_cnt each cycle.
REQ-021 SHALL leave ISSUE after ceil(NUM_ACTS/NUM_LANES) cycles (5 by default) and spend exactly 1 cycle in DRAIN, matching the 1-cycle lane latency.
REQ-022 SHALL pulse sched_done for the DRAIN cycle, then return to IDLE; the list-to-done latency is groups+1 cycles after transfer.
REQ-023 SHALL drive lane_act_valid=0 in IDLE and DRAIN, and SHALL hold lane_act at its last value there.
REQ-024 SHALL ignore act_list_valid outside IDLE; act_list may change freely after transfer.
REQ-025 SHALL hold issued_cnt from DRAIN until the next transfer.

Reset
REQ-026 SHALL, while aresetn=0, force state IDLE, ptr=0, lane_act_valid=0, lane_act=0, sched_done=0, issued_cnt=0, and err_oob=0.
REQ-027 SHALL, on reset mid-list, abandon the list with no sched_done; act_list_ready SHALL be 1 on the first cycle after reset release.

Configuration
REQ-028 SHALL, with macro PARSE_BOUNDS_CHECK_EN defined, suppress any valid entry whose offset+size bytes (2/4/6) exceeds HDR_BYTES, with its lane valid forced 0 and not counted, and SHALL set err_oob sticky until reset.
REQ-029 SHALL, without the macro, issue such entries unchecked, with err_oob tied 0.

Structure
REQ-030 SHALL take action field positions, size codes (01=2B, 10=4B, 11=6B) and FSM state encodings from a shared package parse_pkg.
REQ-031 SHALL contain one sub-module, parse_act_check, a combinational per-entry validity and bounds check instantiated NUM_LANES times.

Verification
REQ-032 Bench SHALL cover: all 10 entries valid, 2B at offsets 0..9 -> 5 ISSUE cycles each with lane_act_valid=2'b11, sched_done at cycle 6 after transfer, issued_cnt=10.
REQ-033 Bench SHALL cover: entries 1, 4 and 7 with bit[0]=0 -> those lanes valid 0 in their cycles, issued_cnt=7.
REQ-034 Bench SHALL cover: act_list_valid held high continuously -> act_list_ready=0 for 6 cycles between transfers, with back-to-back lists accepted on the IDLE cycle.
REQ-035 Bench SHALL cover: with PARSE_BOUNDS_CHECK_EN, a 6B entry at offset 125 -> lane valid 0, err_oob=1 persisting into the next list, issued_cnt excluding that entry.
REQ-036 Bench SHALL cover: aresetn=0 during ISSUE cycle 3 -> all outputs 0 next cycle, no sched_done, act_list_ready=1 after release.
REQ-037 Bench SHALL cover: NUM_ACTS=5, NUM_LANES=2 -> 3 ISSUE cycles, lane 1 valid 0 in the third cycle.
